// File: rtl/escritor_embarcacoes.sv
// Ship-position memory writer: validates placement commits, writes accepted
// masks into the per-player ship memory, sweeps both memories clear after
// reset or on request, and tracks per-player occupancy and placed ships.
module escritor_embarcacoes #(
  parameter int NUM_EMB = 11,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               resetGeral,
  input  logic               limpar,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_jogador,
  input  logic [3:0]         cmd_indice,
  input  logic [DATA_W-1:0]  cmd_mascara,
  output logic               resp_valid,
  output logic [1:0]         resp_codigo,
  output logic               mem_we,
  output logic               mem_jogador,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_data,
  output logic [DATA_W-1:0]  ocupacao_j0,
  output logic [DATA_W-1:0]  ocupacao_j1,
  output logic [NUM_EMB-1:0] colocadas_j0,
  output logic [NUM_EMB-1:0] colocadas_j1,
  output logic               pronto_j0,
  output logic               pronto_j1
);

  localparam int CLR_WORDS = 2 * NUM_EMB;
  localparam int PTR_W     = $clog2(CLR_WORDS + 1);

  localparam logic [1:0] RC_OK      = 2'b00;
  localparam logic [1:0] RC_OVERLAP = 2'b01;
  localparam logic [1:0] RC_BAD     = 2'b10;
  localparam logic [1:0] RC_DUP     = 2'b11;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_CHECK = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t state, state_n;

  // clear-sweep pointer: 0..CLR_WORDS-1 are words to write, CLR_WORDS means done
  logic [PTR_W-1:0]   ptr, ptr_n;

  // latched command
  logic               lat_jog, lat_jog_n;
  logic [3:0]         lat_idx, lat_idx_n;
  logic [DATA_W-1:0]  lat_mask, lat_mask_n;

  // next values of registered outputs
  logic               we_n;
  logic               mjog_n;
  logic [ADDR_W-1:0]  maddr_n;
  logic [DATA_W-1:0]  mdata_n;
  logic               rv_n;
  logic [1:0]         rc_n;
  logic [DATA_W-1:0]  occ0_n, occ1_n;
  logic [NUM_EMB-1:0] plc0_n, plc1_n;

  // check helpers
  logic [NUM_EMB-1:0] sel_plc;
  logic [DATA_W-1:0]  sel_occ;
  logic [15:0]        plc_pad;
  logic [NUM_EMB-1:0] idx_bit;
  logic [1:0]         code;

  assign cmd_ready = (state == S_IDLE);

  // classify the latched command; first matching rule wins
  always_comb begin
    sel_plc = lat_jog ? colocadas_j1 : colocadas_j0;
    sel_occ = lat_jog ? ocupacao_j1  : ocupacao_j0;
    plc_pad = 16'(sel_plc);
    idx_bit = NUM_EMB'(1) << lat_idx;
    code    = RC_OK;
    if (lat_idx >= 4'(NUM_EMB) || lat_mask == '0)
      code = RC_BAD;
    else if (plc_pad[lat_idx])
      code = RC_DUP;
    else if ((lat_mask & sel_occ) != '0)
      code = RC_OVERLAP;
  end

  // next state plus next values of every registered output
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    lat_jog_n  = lat_jog;
    lat_idx_n  = lat_idx;
    lat_mask_n = lat_mask;
    we_n       = 1'b0;
    mjog_n     = mem_jogador;
    maddr_n    = mem_addr;
    mdata_n    = mem_data;
    rv_n       = 1'b0;
    rc_n       = RC_OK;
    occ0_n     = ocupacao_j0;
    occ1_n     = ocupacao_j1;
    plc0_n     = colocadas_j0;
    plc1_n     = colocadas_j1;

    case (state)
      S_CLEAR: begin
        // limpar is deliberately ignored here; the sweep always completes
        if (ptr == PTR_W'(CLR_WORDS)) begin
          state_n = S_IDLE;
          ptr_n   = '0;
        end else begin
          we_n    = 1'b1;
          mdata_n = '0;
          if (ptr < PTR_W'(NUM_EMB)) begin
            mjog_n  = 1'b0;
            maddr_n = ADDR_W'(ptr);
          end else begin
            mjog_n  = 1'b1;
            maddr_n = ADDR_W'(ptr - PTR_W'(NUM_EMB));
          end
          ptr_n = ptr + PTR_W'(1);
        end
      end

      S_IDLE: begin
        if (limpar) begin
          // clear wins over a simultaneous commit, which is dropped
          state_n = S_CLEAR;
          ptr_n   = '0;
          occ0_n  = '0;
          occ1_n  = '0;
          plc0_n  = '0;
          plc1_n  = '0;
        end else if (cmd_valid) begin
          lat_jog_n  = cmd_jogador;
          lat_idx_n  = cmd_indice;
          lat_mask_n = cmd_mascara;
          state_n    = S_CHECK;
        end
      end

      S_CHECK: begin
        if (code == RC_OK) begin
          state_n = S_WRITE;
          we_n    = 1'b1;
          mjog_n  = lat_jog;
          maddr_n = ADDR_W'(lat_idx);
          mdata_n = lat_mask;
        end else begin
          state_n = S_RESP;
          rv_n    = 1'b1;
          rc_n    = code;
        end
      end

      S_WRITE: begin
        // the edge that ends the write commits occupancy and placed bit
        if (lat_jog) begin
          occ1_n = ocupacao_j1 | lat_mask;
          plc1_n = colocadas_j1 | idx_bit;
        end else begin
          occ0_n = ocupacao_j0 | lat_mask;
          plc0_n = colocadas_j0 | idx_bit;
        end
        state_n = S_RESP;
        rv_n    = 1'b1;
        rc_n    = RC_OK;
      end

      S_RESP: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_CLEAR;
        ptr_n   = '0;
      end
    endcase
  end

  // state and registered outputs; async reset restarts the clear sweep
  always_ff @(posedge clk or posedge resetGeral) begin
    if (resetGeral) begin
      state        <= S_CLEAR;
      ptr          <= '0;
      lat_jog      <= 1'b0;
      lat_idx      <= '0;
      lat_mask     <= '0;
      mem_we       <= 1'b0;
      mem_jogador  <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      resp_valid   <= 1'b0;
      resp_codigo  <= RC_OK;
      ocupacao_j0  <= '0;
      ocupacao_j1  <= '0;
      colocadas_j0 <= '0;
      colocadas_j1 <= '0;
      pronto_j0    <= 1'b0;
      pronto_j1    <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      lat_jog      <= lat_jog_n;
      lat_idx      <= lat_idx_n;
      lat_mask     <= lat_mask_n;
      mem_we       <= we_n;
      mem_jogador  <= mjog_n;
      mem_addr     <= maddr_n;
      mem_data     <= mdata_n;
      resp_valid   <= rv_n;
      resp_codigo  <= rc_n;
      ocupacao_j0  <= occ0_n;
      ocupacao_j1  <= occ1_n;
      colocadas_j0 <= plc0_n;
      colocadas_j1 <= plc1_n;
      pronto_j0    <= &plc0_n;
      pronto_j1    <= &plc1_n;
    end
  end

endmodule
